fifo_param: RTL
===============

Name: fifo_param

Overview:
Parametrised synchronous single-clock FIFO, next generation of the team's 8-bit/16-entry FIFO. Width, depth and almost-full/almost-empty thresholds are configurable. Adds an occupancy count, sticky overflow/underflow error flags and simultaneous push-on-full. Sits between producer/consumer datapaths and is the target of the team's formal FIFO property set.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AW, $clog2(DEPTH), pointer index width (derived, not overridden)
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low (rst=0 resets on the next clk rising edge)
wen  in  1  write request
wdata  in  WIDTH  write data
ren  in  1  read request
clr_err  in  1  clears sticky error flags
rdata  out  WIDTH  read data
rvalid  out  1  rdata holds a popped word this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: a read hit an empty FIFO

Behaviour:
- Storage: DEPTH x WIDTH array. Pointers wr_ptr and rd_ptr are AW+1 bits; index = low AW bits; MSB is the wrap bit. full/empty are derived from pointer compare. count = wr_ptr - rd_ptr, modulo 2^(AW+1).
- Reset (rst=0 at clk edge): pointers=0, rdata=0, rvalid=0, overflow=0, underflow=0. Outputs then read empty=1, full=0, count=0, almost_empty=1, almost_full=0. Array contents are not reset. Reset has priority over all other inputs, including mid-stream traffic.
- Read accept: rd_acc = ren & !empty.
- Write accept: wr_acc = wen & (!full | rd_acc). A push on full is accepted when a read is accepted in the same cycle.
- On wr_acc: array[wr_ptr] <= wdata; wr_ptr++.
- On rd_acc: rd_ptr++.
- Simultaneous wr_acc and rd_acc: count is unchanged.
- Empty with wen=1 and ren=1: write accepted, read rejected, underflow set, count goes to 1.
- Default mode (no macro): rdata <= array[rd_ptr] and rvalid <= 1 on rd_acc, so read latency is 1 cycle. Otherwise rvalid <= 0 and rdata holds its last value.
- overflow <= 1 when wen & !wr_acc. underflow <= 1 when ren & empty.
- clr_err=1 clears both flags. A new error in the same cycle wins, so the flag stays 1.
- Pointer wrap: index returns to 0 after DEPTH-1 and the wrap bit toggles. There is no data corruption across the wrap.
- All status outputs (full, empty, almost_*, count) are combinational from the pointers and update the cycle after the accepting edge.

Optional Feature:
FIFO_FWFT_EN: first-word-fall-through mode.
- Defined: rdata = array[rd_ptr] combinationally and rvalid = !empty. The head word is visible before ren, and ren acts as pop/acknowledge. Latency from write to visible data is 1 cycle after the write edge. Accept, count and error rules are unchanged.
- Undefined: the registered 1-cycle read described in Behaviour.

Test Plan:
- Reset: drive rst=0 for 2 cycles with wen=1, wdata=8'hAA -> count=0, empty=1, almost_empty=1, rvalid=0, no write stored (a subsequent ren gives underflow=1).
- Fill/drain, DEPTH=16: write 0x00..0x0F -> full=1 and count=16; almost_full=1 from count=14. Then read 16 -> rdata sequence 0x00..0x0F with rvalid each cycle after ren, empty=1 at end.
- Wrap: repeat 40 cycles of interleaved write/read with incrementing data -> data order preserved across 2+ pointer wraps; count oscillates 0..1.
- Full + simultaneous wen/ren: at count=16, wen=1, wdata=8'h55, ren=1 -> overflow stays 0 and count stays 16. Then wen alone -> overflow=1 and count=16. Then clr_err=1 -> overflow=0.
- Empty + simultaneous: at count=0, wen=1, wdata=8'h80, ren=1 -> underflow=1, count=1, rvalid=0. Next ren -> rdata=8'h80.
- FWFT build (FIFO_FWFT_EN): write 8'h02 -> next cycle rvalid=1 and rdata=8'h02 with no ren. Assert ren -> empty=1 and rvalid=0 the following cycle.

Source files
------------

// File: rtl/fifo_param.sv
// ============================================================================
// fifo_param : parametrised single-clock FIFO with occupancy count, sticky
//              overflow/underflow flags and push-on-full when popping.
// Optional:    FIFO_FWFT_EN selects first-word-fall-through read port.
// Revision:    1.0  initial release
// ============================================================================
`default_nettype none

module fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  input  logic             clr_err,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             rd_acc;
  logic             wr_acc;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (int'(count) >= AF_THRESH);
  assign almost_empty = (int'(count) <= AE_THRESH);

  assign rd_acc = ren & ~empty;
  assign wr_acc = wen & (~full | rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // A fresh error in the same cycle as clr_err keeps the flag set.
      overflow  <= (wen & ~wr_acc) | (overflow & ~clr_err);
      underflow <= (ren & empty)   | (underflow & ~clr_err);
    end
  end

`ifdef FIFO_FWFT_EN
  assign rdata  = mem[rd_ptr[AW-1:0]];
  assign rvalid = ~empty;
`else
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

endmodule

`default_nettype wire
